// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector multiplier.
// Provides the controller state encoding and the packed-bus element offset helper.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // LSB position of element idx in a flat bus of count elements, element 0 in the MSBs.
    function automatic int unsigned elem_lsb(input int unsigned idx,
                                             input int unsigned count,
                                             input int unsigned width);
        return (count - 1 - idx) * width;
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One row of the multiplier: WIDTH-bit wrapping multiply-accumulate.
// Ports:
//   clk, reset  - clock, async active-low reset
//   clear       - synchronous clear of the accumulator (takes priority over en)
//   en          - accumulate a*b this cycle
//   a, b        - unsigned operands
//   acc         - registered accumulator (modulo 2^WIDTH)
module mvm_mac_lane
    import mvm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] acc_q;

    // Product and sum both wrap at WIDTH bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + WIDTH'(a * b);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mvm_core.sv
// Unsigned matrix-vector multiplier: rows in parallel, shared dimension one column per clock.
// Ports:
//   clk, reset     - clock, async active-low reset
//   start          - begin a computation (accepted in IDLE or DONE, ignored while BUSY)
//   matrix         - MATRIX_ROWS x SHARED_DIM row-major, element (0,0) in the MSBs
//   vector         - SHARED_DIM elements, element 0 in the MSBs
//   result_vector  - MATRIX_ROWS elements, row 0 in the MSBs; holds until the next result
//   done           - level, high while result_vector holds a finished result
module mvm_core
    import mvm_pkg::*;
#(
    parameter int unsigned MATRIX_ROWS = 3,
    parameter int unsigned SHARED_DIM  = 3,
    parameter int unsigned WIDTH       = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
    input  logic [SHARED_DIM*WIDTH-1:0]             vector,
    output logic [MATRIX_ROWS*WIDTH-1:0]            result_vector,
    output logic                                    done
);

    localparam int unsigned MW = MATRIX_ROWS * SHARED_DIM * WIDTH;
    localparam int unsigned VW = SHARED_DIM * WIDTH;
    localparam int unsigned RW = MATRIX_ROWS * WIDTH;
    localparam int unsigned KW = (SHARED_DIM > 1) ? $clog2(SHARED_DIM) : 1;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [MW-1:0]   mat_q, mat_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [RW-1:0]   res_q, res_d;
    logic            done_q, done_d;

    logic            clear_c;
    logic            en_c;
    logic            last_c;
    logic [WIDTH-1:0] vcol_c;
    logic [RW-1:0]   final_c;

    // Column k of the captured vector, shared by every row.
    assign vcol_c = vec_q[elem_lsb(32'(k_q), SHARED_DIM, WIDTH) +: WIDTH];
    assign last_c = (k_q == KW'(SHARED_DIM - 1));

    // Per-row column mux, MAC lane, and the value the lane reaches at this edge.
    for (genvar r = 0; r < MATRIX_ROWS; r++) begin : g_row
        logic [WIDTH-1:0] a_c;
        logic [WIDTH-1:0] acc;

        assign a_c = mat_q[elem_lsb(32'(r) * SHARED_DIM + 32'(k_q),
                                    MATRIX_ROWS * SHARED_DIM, WIDTH) +: WIDTH];

        mvm_mac_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (clear_c),
            .en    (en_c),
            .a     (a_c),
            .b     (vcol_c),
            .acc   (acc)
        );

        // Result is loaded on the same edge as the last accumulate, so fold in that product here.
        assign final_c[elem_lsb(32'(r), MATRIX_ROWS, WIDTH) +: WIDTH] = acc + WIDTH'(a_c * vcol_c);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mat_d   = mat_q;
        vec_d   = vec_q;
        res_d   = res_q;
        done_d  = done_q;
        clear_c = 1'b0;
        en_c    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mat_d   = matrix;
                    vec_d   = vector;
                    k_d     = '0;
                    clear_c = 1'b1;
                    done_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                en_c = 1'b1;
                k_d  = k_q + KW'(1);
                if (last_c) begin
                    k_d     = '0;
                    res_d   = final_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            mat_q   <= '0;
            vec_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign result_vector = res_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mvm_core.sv
// Directed bench for mvm_core: 3x3, 6x3 and 2x4 instances with hand-computed results.
module tb_mvm_core;

    logic clk = 1'b0;
    logic reset;

    logic         start33, start63, start24;
    logic [71:0]  matrix33;
    logic [23:0]  vector33;
    logic [23:0]  result33;
    logic         done33;
    logic [143:0] matrix63;
    logic [23:0]  vector63;
    logic [47:0]  result63;
    logic         done63;
    logic [63:0]  matrix24;
    logic [31:0]  vector24;
    logic [15:0]  result24;
    logic         done24;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mvm_core #(.MATRIX_ROWS(3), .SHARED_DIM(3), .WIDTH(8)) u_dut33 (
        .clk(clk), .reset(reset), .start(start33), .matrix(matrix33),
        .vector(vector33), .result_vector(result33), .done(done33)
    );

    mvm_core #(.MATRIX_ROWS(6), .SHARED_DIM(3), .WIDTH(8)) u_dut63 (
        .clk(clk), .reset(reset), .start(start63), .matrix(matrix63),
        .vector(vector63), .result_vector(result63), .done(done63)
    );

    mvm_core #(.MATRIX_ROWS(2), .SHARED_DIM(4), .WIDTH(8)) u_dut24 (
        .clk(clk), .reset(reset), .start(start24), .matrix(matrix24),
        .vector(vector24), .result_vector(result24), .done(done24)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Start the 3x3 instance and check done timing (exactly 3 edges) and the result.
    task automatic run33(input string tag, input logic [71:0] m, input logic [23:0] v,
                         input logic [23:0] exp_res, input logic [23:0] old_res);
        matrix33 = m;
        vector33 = v;
        start33  = 1'b1;
        tick();
        start33  = 1'b0;
        check({tag, "_done_low_e0"}, 64'(done33), 64'd0);
        check({tag, "_old_result_held"}, 64'(result33), 64'(old_res));
        tick();
        check({tag, "_done_low_e1"}, 64'(done33), 64'd0);
        tick();
        check({tag, "_done_low_e2"}, 64'(done33), 64'd0);
        tick();
        check({tag, "_done_e3"}, 64'(done33), 64'd1);
        check({tag, "_result"}, 64'(result33), 64'(exp_res));
    endtask

    initial begin
        reset    = 1'b0;
        start33  = 1'b0;
        start63  = 1'b0;
        start24  = 1'b0;
        matrix33 = '0;
        vector33 = '0;
        matrix63 = '0;
        vector63 = '0;
        matrix24 = '0;
        vector24 = '0;

        tick();
        tick();
        check("reset_done33", 64'(done33), 64'd0);
        check("reset_res33", 64'(result33), 64'd0);
        check("reset_done63", 64'(done63), 64'd0);
        check("reset_res63", 64'(result63), 64'd0);
        check("reset_done24", 64'(done24), 64'd0);
        check("reset_res24", 64'(result24), 64'd0);
        reset = 1'b1;
        tick();

        // Case 1: basic 3x3.
        run33("c1", 72'h010203040506070809, 24'h010203, 24'h0E2032, 24'h000000);
        tick();
        tick();
        check("c1_done_hold", 64'(done33), 64'd1);
        check("c1_result_hold", 64'(result33), 64'h0E2032);

        // Case 2: restart straight from DONE; old result visible until the new one loads.
        run33("c2", 72'h0A0B0C0D0E0F101111, 24'h040506, 24'hA7D4FB, 24'h0E2032);

        // Case 3: wrap-around modulo 256.
        run33("c3", 72'h131415161718191A1B, 24'h070809, 24'hE22A72, 24'hA7D4FB);

        // Case 4: 6x3, latency 3.
        matrix63 = 144'h0102030405060708090A0B0C0D0E0F101112;
        vector63 = 24'h010203;
        start63  = 1'b1;
        tick();
        start63  = 1'b0;
        tick();
        tick();
        check("c4_done_low_e2", 64'(done63), 64'd0);
        tick();
        check("c4_done_e3", 64'(done63), 64'd1);
        check("c4_result", 64'(result63), 64'h0E2032445668);

        // Case 5: 2x4; operands scrambled and start pulsed while BUSY.
        matrix24 = 64'h0102030405060708;
        vector24 = 32'h01020304;
        start24  = 1'b1;
        tick();
        start24  = 1'b0;
        matrix24 = 64'hFFEEDDCCBBAA9988;
        vector24 = 32'h77665544;
        tick();
        start24  = 1'b1;
        tick();
        start24  = 1'b0;
        check("c5_done_low_e2", 64'(done24), 64'd0);
        tick();
        check("c5_done_low_e3", 64'(done24), 64'd0);
        tick();
        check("c5_done_e4", 64'(done24), 64'd1);
        check("c5_result", 64'(result24), 64'h1E46);
        tick();
        tick();
        tick();
        check("c5_no_restart", 64'(done24), 64'd1);

        // Case 6: asynchronous reset mid-BUSY clears everything immediately.
        matrix33 = 72'h131415161718191A1B;
        vector33 = 24'h070809;
        start33  = 1'b1;
        tick();
        start33  = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("c6_reset_done", 64'(done33), 64'd0);
        check("c6_reset_result", 64'(result33), 64'd0);
        check("c6_reset_res63", 64'(result63), 64'd0);
        tick();
        #2;
        reset = 1'b1;
        tick();
        check("c6_idle_after_reset", 64'(done33), 64'd0);
        run33("c6", 72'h010203040506070809, 24'h010203, 24'h0E2032, 24'h000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
